// File: rtl/ctrl_hazard_scoreboard_pkg.sv
// Shared types for the CTRL in-flight scoreboard: core widths, CSR micro-ops,
// and the WB commit payload that doubles as the scoreboard entry format.
package ctrl_hazard_scoreboard_pkg;

  localparam int unsigned RF_ADDR_WIDTH    = 5;
  localparam int unsigned CSR_ADDR_WIDTH   = 12;
  localparam int unsigned CSR_CTRL_WIDTH   = 3;
  localparam int unsigned SB_DEPTH_DEFAULT = 4;

  typedef enum logic [CSR_CTRL_WIDTH-1:0] {
    CSR_CTRL_NONE = 3'd0,
    CSR_CTRL_RW   = 3'd1,
    CSR_CTRL_RS   = 3'd2,
    CSR_CTRL_RC   = 3'd3,
    CSR_CTRL_RWI  = 3'd4,
    CSR_CTRL_RSI  = 3'd5,
    CSR_CTRL_RCI  = 3'd6
  } csr_ctrl_e;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0]  rd;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
    logic [CSR_CTRL_WIDTH-1:0] csr_ctrl;
  } wb2ctrl_t;

  typedef wb2ctrl_t sb_entry_t;

  function automatic logic writes_csr(input sb_entry_t e);
    return e.csr_ctrl != CSR_CTRL_NONE;
  endfunction

endpackage

// File: rtl/ctrl_hazard_scoreboard_inflight_fifo.sv
// Circular in-order FIFO of in-flight instructions with push, pop and
// flush truncation; exposes every slot plus a per-slot valid mask.
module ctrl_inflight_fifo
  import ctrl_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned SB_DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned CNT_W    = $clog2(SB_DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      push_i,
  input  sb_entry_t                 push_entry_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [CNT_W-1:0]          flush_keep_i,
  output sb_entry_t [SB_DEPTH-1:0]  entries_o,
  output logic [SB_DEPTH-1:0]       valid_o,
  output sb_entry_t                 head_entry_o,
  output logic [CNT_W-1:0]          count_o,
  output logic                      trunc_err_o
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);

  sb_entry_t [SB_DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]         head_q, tail_q, head_nxt;
  logic [CNT_W-1:0]         count_q, kept, new_cnt;

  always_comb begin
    head_nxt    = head_q + PTR_W'(pop_i);
    kept        = (flush_keep_i > count_q) ? count_q : flush_keep_i;
    trunc_err_o = flush_i & ((flush_keep_i > count_q) | ((flush_keep_i == '0) & pop_i));
    // The popped head belongs to the kept set, so it comes out of the kept count.
    if (flush_i) begin
      new_cnt = (kept < CNT_W'(pop_i)) ? '0 : kept - CNT_W'(pop_i);
    end else begin
      new_cnt = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_comb begin
    valid_o = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      valid_o[i] = CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_nxt;
      count_q <= new_cnt;
      if (flush_i) begin
        tail_q <= head_nxt + new_cnt[PTR_W-1:0];
      end else if (push_i) begin
        mem_q[tail_q] <= push_entry_i;
        tail_q        <= tail_q + 1'b1;
      end
    end
  end

  assign entries_o    = mem_q;
  assign head_entry_o = mem_q[head_q];
  assign count_o      = count_q;

endmodule

// File: rtl/ctrl_hazard_scoreboard.sv
// CTRL in-flight scoreboard: stalls ID on GPR/CSR RAW hazards against
// uncommitted instructions and flags WB/flush protocol errors.
module ctrl_hazard_scoreboard
  import ctrl_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned SB_DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned CNT_W    = $clog2(SB_DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      issue_valid_i,
  input  logic [RF_ADDR_WIDTH-1:0]  issue_rd_i,
  input  logic [CSR_ADDR_WIDTH-1:0] issue_csr_waddr_i,
  input  logic [CSR_CTRL_WIDTH-1:0] issue_csr_ctrl_i,
  input  logic [RF_ADDR_WIDTH-1:0]  id_rs1_i,
  input  logic [RF_ADDR_WIDTH-1:0]  id_rs2_i,
  input  logic                      id_csr_read_i,
  input  logic [CSR_ADDR_WIDTH-1:0] id_csr_raddr_i,
  input  logic                      wb_valid_i,
  input  wb2ctrl_t                  wb2ctrl_i,
  input  logic                      flush_i,
  input  logic [CNT_W-1:0]          flush_keep_i,
  output logic                      stall_o,
  output logic                      full_o,
  output logic [CNT_W-1:0]          inflight_o,
  output logic                      err_o
);

  sb_entry_t [SB_DEPTH-1:0] entries;
  logic [SB_DEPTH-1:0]      valid;
  sb_entry_t                head_entry, issue_entry;
  logic [CNT_W-1:0]         count;
  logic                     trunc_err, empty, issue_fire, pop;
  logic                     gpr_haz, csr_haz;

  assign issue_entry = '{rd: issue_rd_i, csr_waddr: issue_csr_waddr_i, csr_ctrl: issue_csr_ctrl_i};
  assign empty       = (count == '0);
  assign full_o      = (count == CNT_W'(SB_DEPTH));
  assign inflight_o  = count;
  assign pop         = wb_valid_i & ~empty;
  assign stall_o     = issue_valid_i & (gpr_haz | csr_haz | full_o);
  assign issue_fire  = issue_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    gpr_haz = 1'b0;
    csr_haz = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (valid[i]) begin
        if ((entries[i].rd != '0) &&
            ((entries[i].rd == id_rs1_i) || (entries[i].rd == id_rs2_i))) begin
          gpr_haz = 1'b1;
        end
        if (id_csr_read_i && writes_csr(entries[i]) &&
            (entries[i].csr_waddr == id_csr_raddr_i)) begin
          csr_haz = 1'b1;
        end
      end
    end
  end

  ctrl_inflight_fifo #(
    .SB_DEPTH (SB_DEPTH),
    .CNT_W    (CNT_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .push_i       (issue_fire),
    .push_entry_i (issue_entry),
    .pop_i        (pop),
    .flush_i      (flush_i),
    .flush_keep_i (flush_keep_i),
    .entries_o    (entries),
    .valid_o      (valid),
    .head_entry_o (head_entry),
    .count_o      (count),
    .trunc_err_o  (trunc_err)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_o <= 1'b0;
    end else if ((wb_valid_i & empty) | (pop & (head_entry != wb2ctrl_i)) | trunc_err) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_hazard_scoreboard.sv
// Directed vector bench for ctrl_hazard_scoreboard (SB_DEPTH = 4).
module tb_ctrl_hazard_scoreboard;
  import ctrl_hazard_scoreboard_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic [11:0] issue_csr_waddr_i;
  logic [2:0]  issue_csr_ctrl_i;
  logic [4:0]  id_rs1_i, id_rs2_i;
  logic        id_csr_read_i;
  logic [11:0] id_csr_raddr_i;
  logic        wb_valid_i;
  wb2ctrl_t    wb2ctrl_i;
  logic        flush_i;
  logic [2:0]  flush_keep_i;
  logic        stall_o, full_o, err_o;
  logic [2:0]  inflight_o;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  ctrl_hazard_scoreboard #(.SB_DEPTH(4)) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .issue_valid_i     (issue_valid_i),
    .issue_rd_i        (issue_rd_i),
    .issue_csr_waddr_i (issue_csr_waddr_i),
    .issue_csr_ctrl_i  (issue_csr_ctrl_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_csr_read_i     (id_csr_read_i),
    .id_csr_raddr_i    (id_csr_raddr_i),
    .wb_valid_i        (wb_valid_i),
    .wb2ctrl_i         (wb2ctrl_i),
    .flush_i           (flush_i),
    .flush_keep_i      (flush_keep_i),
    .stall_o           (stall_o),
    .full_o            (full_o),
    .inflight_o        (inflight_o),
    .err_o             (err_o)
  );

  typedef struct {
    logic rstn; logic iv; logic [4:0] ird; logic [11:0] icsra; logic [2:0] icsrc;
    logic [4:0] rs1; logic [4:0] rs2; logic cr; logic [11:0] cra;
    logic wv; logic [4:0] wrd; logic [11:0] wcsra; logic [2:0] wcsrc;
    logic fl; logic [2:0] keep;
    logic es; logic [2:0] einf; logic efull; logic eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rstn, logic iv, logic [4:0] ird, logic [11:0] icsra, logic [2:0] icsrc,
                              logic [4:0] rs1, logic [4:0] rs2, logic cr, logic [11:0] cra,
                              logic wv, logic [4:0] wrd, logic [11:0] wcsra, logic [2:0] wcsrc,
                              logic fl, logic [2:0] keep,
                              logic es, logic [2:0] einf, logic efull, logic eerr);
    vec_t v;
    v.rstn = rstn; v.iv = iv; v.ird = ird; v.icsra = icsra; v.icsrc = icsrc;
    v.rs1 = rs1; v.rs2 = rs2; v.cr = cr; v.cra = cra;
    v.wv = wv; v.wrd = wrd; v.wcsra = wcsra; v.wcsrc = wcsrc;
    v.fl = fl; v.keep = keep;
    v.es = es; v.einf = einf; v.efull = efull; v.eerr = eerr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rstn_i = v.rstn; issue_valid_i = v.iv; issue_rd_i = v.ird;
    issue_csr_waddr_i = v.icsra; issue_csr_ctrl_i = v.icsrc;
    id_rs1_i = v.rs1; id_rs2_i = v.rs2; id_csr_read_i = v.cr; id_csr_raddr_i = v.cra;
    wb_valid_i = v.wv; wb2ctrl_i = '{rd: v.wrd, csr_waddr: v.wcsra, csr_ctrl: v.wcsrc};
    flush_i = v.fl; flush_keep_i = v.keep;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  initial begin
    vec_t v, idle;
    idle = mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0);
    drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0));

    //         rstn iv ird icsra  icsrc rs1 rs2 cr cra     wv wrd wcsra  wcsrc fl keep | stall inf full err
    vecs.push_back(mk(0,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,1, 1,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,1, 2,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,2,0,0));
    vecs.push_back(mk(1,1, 3,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,3,0,0));
    vecs.push_back(mk(0,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,0));
    // RAW on rd=5: stall holds through the commit cycle
    vecs.push_back(mk(1,1, 5,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,1, 7,12'h000,0,  5,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 1,1,0,0));
    vecs.push_back(mk(1,1, 7,12'h000,0,  5,0, 0,12'h000, 1, 5,12'h000,0, 0,0, 1,0,0,0));
    vecs.push_back(mk(1,1, 7,12'h000,0,  5,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 7,12'h000,0, 0,0, 0,0,0,0));
    // rd=x0 entries are tracked but never hazard
    vecs.push_back(mk(1,1, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,1, 6,12'h000,0,  0,0, 0,12'h000, 1, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 6,12'h000,0, 0,0, 0,0,0,0));
    // fill to 4, blocked 5th, push+pop with wrap
    vecs.push_back(mk(1,1, 1,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,1, 2,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,2,0,0));
    vecs.push_back(mk(1,1, 3,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,3,0,0));
    vecs.push_back(mk(1,1, 4,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,4,1,0));
    vecs.push_back(mk(1,1, 8,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 1,4,1,0));
    vecs.push_back(mk(1,1, 8,12'h000,0,  0,0, 0,12'h000, 1, 1,12'h000,0, 0,0, 1,3,0,0));
    vecs.push_back(mk(1,1, 8,12'h000,0,  0,0, 0,12'h000, 1, 2,12'h000,0, 0,0, 0,3,0,0));
    vecs.push_back(mk(1,1, 9,12'h000,0,  0,0, 0,12'h000, 1, 3,12'h000,0, 0,0, 0,3,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 4,12'h000,0, 0,0, 0,2,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 8,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 9,12'h000,0, 0,0, 0,0,0,0));
    // flush keep=1, then flush+commit keep=2
    vecs.push_back(mk(1,1, 1,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,1, 2,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,2,0,0));
    vecs.push_back(mk(1,1, 3,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,3,0,0));
    vecs.push_back(mk(1,1,10,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 1,1, 0,1,0,0));
    vecs.push_back(mk(1,1,11,12'h000,0,  3,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,2,0,0));
    vecs.push_back(mk(1,1,12,12'h000,0,  1,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 1,2,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 1,12'h000,0, 1,2, 0,1,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1,11,12'h000,0, 0,0, 0,0,0,0));
    // CSR RAW on 0x300
    vecs.push_back(mk(1,1, 0,12'h300,1,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,1, 0,12'h000,0,  0,0, 1,12'h300, 0, 0,12'h000,0, 0,0, 1,1,0,0));
    vecs.push_back(mk(1,1, 0,12'h000,0,  0,0, 1,12'h305, 0, 0,12'h000,0, 0,0, 0,2,0,0));
    vecs.push_back(mk(1,1, 0,12'h000,0,  0,0, 1,12'h000, 1, 0,12'h300,1, 0,0, 0,2,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 0,12'h000,0, 0,0, 0,0,0,0));
    // errors: commit on empty, head mismatch, keep > count
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 0,12'h000,0, 0,0, 0,0,0,1));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,1));
    vecs.push_back(mk(0,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,1, 4,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 1, 5,12'h000,0, 0,0, 0,0,0,1));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,1));
    vecs.push_back(mk(0,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(1,1, 2,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(1,0, 0,12'h000,0,  0,0, 0,12'h000, 0, 0,12'h000,0, 1,3, 0,1,0,1));

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i]);
      #1;
      chk("stall", i, 32'(stall_o), 32'(vecs[i].es));
      @(posedge clk_i);
      #1;
      chk("inflight", i, 32'(inflight_o), 32'(vecs[i].einf));
      chk("full", i, 32'(full_o), 32'(vecs[i].efull));
      chk("err", i, 32'(err_o), 32'(vecs[i].eerr));
    end

    // Async reset between clock edges with two entries in flight
    @(negedge clk_i); v = idle; v.rstn = 0; drive(v);
    @(negedge clk_i); drive(idle);
    @(negedge clk_i); v = idle; v.iv = 1; v.ird = 3; drive(v);
    @(negedge clk_i); v.ird = 4; drive(v);
    @(negedge clk_i); drive(idle);
    #1 chk("pre_async_inflight", 100, 32'(inflight_o), 32'd2);
    #1 rstn_i = 0;
    #1 chk("async_inflight", 101, 32'(inflight_o), 32'd0);
    chk("async_err", 101, 32'(err_o), 32'd0);
    issue_valid_i = 1; id_rs1_i = 5'd3;
    #1 chk("async_stall", 101, 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    chk("async_hold_inflight", 102, 32'(inflight_o), 32'd0);
    chk("async_hold_full", 102, 32'(full_o), 32'd0);

    // flush keep=0 together with a commit clamps to empty and flags an error
    @(negedge clk_i); drive(idle);
    @(negedge clk_i); v = idle; v.iv = 1; v.ird = 3; drive(v);
    @(negedge clk_i); v = idle; v.fl = 1; v.keep = 0; v.wv = 1; v.wrd = 3; drive(v);
    @(posedge clk_i); #1;
    chk("keep0_inflight", 103, 32'(inflight_o), 32'd0);
    chk("keep0_err", 103, 32'(err_o), 32'd1);
    @(negedge clk_i); drive(idle);
    @(posedge clk_i); #1;
    chk("keep0_err_sticky", 104, 32'(err_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
